clockworks_gearbox: RTL and testbench

Clock and reset front end for the SOC. It sits between the board pins (`CLK`, `RESET`) and the processor/memory. It produces the system clock `clk`, which is either the board clock or an optionally slowed-down copy of it, so instruction execution is visible on the LEDs. It also produces a clean, stretched, active-low reset `resetn` in the `clk` domain.

---
 rtl/clockworks_gearbox.sv | 70 +++++++
 tb/tb_clockworks_gearbox.sv | 100 ++++++++++
 2 files changed

// File: rtl/clockworks_gearbox.sv
// Clock/reset front end: optional clock divider plus a synchronized, stretched active-low reset.
// Define CLOCKWORKS_GEARBOX_EN to slow clk to CLK/2^SLOW; leave undefined to pass CLK straight through.
module clockworks_gearbox #(
    parameter int SLOW         = 19,
    parameter int RESET_CYCLES = 16
) (
    input  logic CLK,
    input  logic RESET,
    output logic clk,
    output logic resetn
);

    localparam logic [7:0] LP_TARGET = 8'(RESET_CYCLES);

    if (SLOW < 1 || SLOW > 30) begin : g_bad_slow
        $error("clockworks_gearbox: SLOW out of range 1..30");
    end
    if (RESET_CYCLES < 1 || RESET_CYCLES > 255) begin : g_bad_cycles
        $error("clockworks_gearbox: RESET_CYCLES out of range 1..255");
    end

    // Synchronizer holds the inverted sense so an all-zero power-up state means "in reset".
    logic [1:0] r_sync_n = 2'b00;
    logic       w_rst_sync;
    logic       w_clk;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_sync_n <= 2'b00;
        end else begin
            r_sync_n <= {r_sync_n[0], 1'b1};
        end
    end

    assign w_rst_sync = ~r_sync_n[1];

`ifdef CLOCKWORKS_GEARBOX_EN
    logic [SLOW-1:0] r_div_cnt = '0;

    always_ff @(posedge CLK or posedge w_rst_sync) begin
        if (w_rst_sync) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign w_clk = r_div_cnt[SLOW-1];
`else
    assign w_clk = CLK;
`endif

    // Stretcher counts clk edges after rst_sync drops and saturates at the target.
    logic [7:0] r_rst_cnt = 8'd0;
    logic       r_resetn  = 1'b0;

    always_ff @(posedge w_clk or posedge w_rst_sync) begin
        if (w_rst_sync) begin
            r_rst_cnt <= 8'd0;
            r_resetn  <= 1'b0;
        end else if (r_rst_cnt < LP_TARGET) begin
            r_rst_cnt <= r_rst_cnt + 8'd1;
            r_resetn  <= ((r_rst_cnt + 8'd1) == LP_TARGET);
        end
    end

    assign clk    = w_clk;
    assign resetn = r_resetn;

endmodule

// File: tb/tb_clockworks_gearbox.sv
// Randomized RESET stimulus on three instances (RESET_CYCLES 16/4/1, SLOW=2), checked against
// edge-count formulas for the divided clock and the reset release point.
module tb_clockworks_gearbox;

    localparam int SLOW_TB = 2;
    localparam int P       = 1 << SLOW_TB;
    localparam int N_CYC   = 3000;

    logic       CLK   = 1'b0;
    logic       RESET = 1'b0;
    logic [2:0] clk_o;
    logic [2:0] resetn_o;

    int rc_tab [3] = '{16, 4, 1};
    int edges   = 0;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    clockworks_gearbox #(.SLOW(SLOW_TB), .RESET_CYCLES(16)) u_a (
        .CLK(CLK), .RESET(RESET), .clk(clk_o[0]), .resetn(resetn_o[0])
    );
    clockworks_gearbox #(.SLOW(SLOW_TB), .RESET_CYCLES(4)) u_b (
        .CLK(CLK), .RESET(RESET), .clk(clk_o[1]), .resetn(resetn_o[1])
    );
    clockworks_gearbox #(.SLOW(SLOW_TB), .RESET_CYCLES(1)) u_c (
        .CLK(CLK), .RESET(RESET), .clk(clk_o[2]), .resetn(resetn_o[2])
    );

    // Expected clk given CLK edges counted since the last reset release.
    function automatic logic exp_clk(input int e, input logic clk_in, input logic rst);
`ifdef CLOCKWORKS_GEARBOX_EN
        if (rst || e < 2) return 1'b0;
        return (((e - 2) % P) >= (P / 2));
`else
        if (rst) return clk_in;
        return clk_in;
`endif
    endfunction

    function automatic logic exp_resetn(input int e, input int rc, input logic rst);
        int release_edge;
`ifdef CLOCKWORKS_GEARBOX_EN
        release_edge = 2 + P / 2 + (rc - 1) * P;
`else
        release_edge = 2 + rc;
`endif
        if (rst) return 1'b0;
        return (e >= release_edge);
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t edges=%0d: got %b expected %b", tag, $time, edges, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        for (int i = 0; i < 3; i++) begin
            check_bit($sformatf("%s clk[%0d]", ph, i), clk_o[i], exp_clk(edges, CLK, RESET));
            check_bit($sformatf("%s resetn[%0d]", ph, i), resetn_o[i], exp_resetn(edges, rc_tab[i], RESET));
        end
    endtask

    initial begin
        int   hold;
        logic asserted;
        logic short_pulse;
        hold = 0;
        #1 check_all("init");
        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(posedge CLK);
            if (!RESET) edges++;
            #1 check_all("pos");
            #2;
            asserted    = 1'b0;
            short_pulse = 1'b0;
            if (RESET) begin
                if (hold == 0) RESET = 1'b0;
                else hold--;
            end else if (cyc >= 300 && cyc < 1800 && $urandom_range(39) == 0) begin
                RESET       = 1'b1;
                edges       = 0;
                asserted    = 1'b1;
                short_pulse = ($urandom_range(2) == 0);
                hold        = $urandom_range(10);
            end
            #1;
            if (asserted) check_all("async");
            #2 check_all("neg");
            if (short_pulse) RESET = 1'b0;
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
